// File: rtl/edge_sync_chain.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | edge_sync_chain: DEPTH-deep flop chain reset to 0; wire if DEPTH=0  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module edge_sync_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_passthrough
            // Clock and reset have no loads when the chain collapses to a wire.
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign dout     = din;
        end else begin : g_chain
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fall_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fall_edge_detect: per-bit registered fall/rise strobes plus a      |
// | saturating count of cycles carrying any falling-edge strobe.       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module fall_edge_detect #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] signal,
    output logic [WIDTH-1:0] ed,
    output logic [WIDTH-1:0] red,
    output logic [CNT_W-1:0] fall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] r_prev;

    edge_sync_chain #(
        .WIDTH (WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (signal),
        .dout (w_cur)
    );

    // r_prev starts at 0, so an input high out of reset yields one rise strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
            ed     <= '0;
            red    <= '0;
        end else begin
            r_prev <= w_cur;
            ed     <= r_prev & ~w_cur;
            red    <= ~r_prev & w_cur;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fall_cnt <= '0;
        end else if (clr) begin
            fall_cnt <= '0;
        end else if ((|ed) && (fall_cnt != c_cnt_max)) begin
            fall_cnt <= fall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fall_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fall_edge_detect: scoreboard bench, two DUT configurations.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_fall_edge_detect;

    localparam int W      = 4;
    localparam int CW_A   = 3;
    localparam int CW_B   = 2;
    localparam int SYNC_B = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clr = 1'b0;
    logic [W-1:0]    sig = '0;
    logic [W-1:0]    ed_a, red_a, ed_b, red_b;
    logic [CW_A-1:0] cnt_a;
    logic [CW_B-1:0] cnt_b;

    fall_edge_detect #(.WIDTH(W), .SYNC_STAGES(0), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .signal(sig),
        .ed(ed_a), .red(red_a), .fall_cnt(cnt_a)
    );

    fall_edge_detect #(.WIDTH(W), .SYNC_STAGES(SYNC_B), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .signal(sig),
        .ed(ed_b), .red(red_b), .fall_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]    ed_a, red_a, ed_b, red_b;
        logic [CW_A-1:0] cnt_a;
        logic [CW_B-1:0] cnt_b;
    } exp_t;

    exp_t         scb[$];
    logic [W-1:0] hist[$];
    int           m_cnt_a, m_cnt_b;
    logic [W-1:0] m_last_ed_a, m_last_ed_b;
    int           compared   = 0;
    int           mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value sampled at the n-th clock edge since reset release; 0 before it.
    function automatic logic [W-1:0] samp(input int n);
        if (n < 0) return '0;
        return hist[n];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_cnt_a     = 0;
        m_cnt_b     = 0;
        m_last_ed_a = '0;
        m_last_ed_b = '0;
    endtask

    // One clock: drive inputs, record the sample, queue the response after the edge.
    task automatic cycle(input logic [W-1:0] s, input logic c);
        exp_t e;
        int   n;
        @(negedge clk);
        rst = 1'b0;
        sig = s;
        clr = c;
        hist.push_back(s);
        n = hist.size() - 1;

        e.ed_a  = samp(n - 1) & ~samp(n);
        e.red_a = ~samp(n - 1) & samp(n);
        e.ed_b  = samp(n - 1 - SYNC_B) & ~samp(n - SYNC_B);
        e.red_b = ~samp(n - 1 - SYNC_B) & samp(n - SYNC_B);

        if (c) m_cnt_a = 0;
        else if (m_last_ed_a != 0) m_cnt_a = (m_cnt_a == 7) ? 7 : m_cnt_a + 1;
        if (c) m_cnt_b = 0;
        else if (m_last_ed_b != 0) m_cnt_b = (m_cnt_b == 3) ? 3 : m_cnt_b + 1;
        e.cnt_a     = CW_A'(m_cnt_a);
        e.cnt_b     = CW_B'(m_cnt_b);
        m_last_ed_a = e.ed_a;
        m_last_ed_b = e.ed_b;
        scb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ed_a"},  32'(ed_a),  0);
        check({tag, "_red_a"}, 32'(red_a), 0);
        check({tag, "_cnt_a"}, 32'(cnt_a), 0);
        check({tag, "_ed_b"},  32'(ed_b),  0);
        check({tag, "_red_b"}, 32'(red_b), 0);
        check({tag, "_cnt_b"}, 32'(cnt_b), 0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scb.size() > 0) begin
                e = scb.pop_front();
                check("ed_a",  32'(ed_a),  32'(e.ed_a));
                check("red_a", 32'(red_a), 32'(e.red_a));
                check("cnt_a", 32'(cnt_a), 32'(e.cnt_a));
                check("ed_b",  32'(ed_b),  32'(e.ed_b));
                check("red_b", 32'(red_b), 32'(e.red_b));
                check("cnt_b", 32'(cnt_b), 32'(e.cnt_b));
            end
        end
    end

    initial begin : stimulus
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        repeat (3) cycle(4'b0000, 1'b0);
        repeat (2) cycle(4'b0001, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0);
        repeat (3) begin
            repeat (2) cycle(4'b0001, 1'b0);
            repeat (2) cycle(4'b0000, 1'b0);
        end
        repeat (3) cycle(4'b0001, 1'b0);
        async_reset();
        repeat (4) cycle(4'b0001, 1'b0);

        repeat (2) cycle(4'b1111, 1'b0);
        cycle(4'b0101, 1'b0);
        cycle(4'b0101, 1'b1);
        repeat (3) cycle(4'b0101, 1'b0);

        repeat (6) begin
            cycle(4'b1111, 1'b0);
            cycle(4'b0000, 1'b0);
        end
        repeat (4) cycle(4'b0000, 1'b0);

        repeat (400) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            cycle(W'($urandom), $urandom_range(0, 15) == 0);
        end
        repeat (4) cycle(4'b0000, 1'b0);

        @(posedge clk);
        #2;
        check("scb_drain", 32'(scb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
